// File: rtl/gpio_config_deserializer_if.sv
// Bus bundle between the PS GPIO block and the configuration deserializer.
//   gpio_in          : raw PS GPIO lines (0 sdata, 1-4 and 7-11 serial clocks,
//                      5 soft reset, 6 trigger)
//   *_reg            : deserialized configuration registers
//   trigger_pulse    : single-cycle pulse per trigger rising edge
//   pl_rst_sync      : synchronised soft-reset level
//   sel_onehot_err   : sel_reg is non-zero and not one-hot
//   shift_strobe     : one bit per register, high on the cycle that register shifts
// The slave modport is the deserializer; the master modport is the PS side.
interface gpio_config_deserializer_if #(
  parameter int GPIO_WIDTH       = 16,
  parameter int CONFIG_REG_WIDTH = 256,
  parameter int MASK_WIDTH       = 32,
  parameter int SEL_WIDTH        = 16,
  parameter int ADC_AVG_WIDTH    = 32,
  parameter int LOCK_WF_WIDTH    = 256
) ();
  logic [GPIO_WIDTH-1:0]       gpio_in;
  logic [MASK_WIDTH-1:0]       mask_reg;
  logic [SEL_WIDTH-1:0]        sel_reg;
  logic [CONFIG_REG_WIDTH-1:0] cycle_count_reg;
  logic                        mux_set_reg;
  logic [ADC_AVG_WIDTH-1:0]    adc_num_avg_reg;
  logic [CONFIG_REG_WIDTH-1:0] adc_num_cycle_reg;
  logic [CONFIG_REG_WIDTH-1:0] pre_delay_reg;
  logic [CONFIG_REG_WIDTH-1:0] post_delay_reg;
  logic [LOCK_WF_WIDTH-1:0]    locking_wf_reg;
  logic                        trigger_pulse;
  logic                        pl_rst_sync;
  logic                        sel_onehot_err;
  logic [8:0]                  shift_strobe;

  modport slave (
    input  gpio_in,
    output mask_reg, sel_reg, cycle_count_reg, mux_set_reg, adc_num_avg_reg,
           adc_num_cycle_reg, pre_delay_reg, post_delay_reg, locking_wf_reg,
           trigger_pulse, pl_rst_sync, sel_onehot_err, shift_strobe
  );

  modport master (
    output gpio_in,
    input  mask_reg, sel_reg, cycle_count_reg, mux_set_reg, adc_num_avg_reg,
           adc_num_cycle_reg, pre_delay_reg, post_delay_reg, locking_wf_reg,
           trigger_pulse, pl_rst_sync, sel_onehot_err, shift_strobe
  );
endinterface

// File: rtl/gpio_config_deserializer.sv
// Fabric-side receiver for the PS GPIO configuration bus.
// Every used GPIO line is synchronised, rising edges on the serial clock lines
// shift the synchronised sdata bit (MSB-first) into the matching register.
// Ports:
//   clk  : fabric clock
//   rst  : asynchronous active-high reset
//   bus  : gpio_config_deserializer_if.slave (gpio_in in, config registers,
//          trigger_pulse, pl_rst_sync, sel_onehot_err, shift_strobe out)

// Per-line synchroniser plus one extra delay flop for edge detection.
module gpio_cfg_sync_line #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic lvl,   // last synchroniser stage
  output logic prev   // lvl delayed by one cycle
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign lvl  = sync_q[SYNC_STAGES-1];
  assign prev = prev_q;
endmodule

module gpio_config_deserializer #(
  parameter int GPIO_WIDTH       = 16,
  parameter int SYNC_STAGES      = 2,
  parameter int CONFIG_REG_WIDTH = 256,
  parameter int MASK_WIDTH       = 32,
  parameter int SEL_WIDTH        = 16,
  parameter int ADC_AVG_WIDTH    = 32,
  parameter int LOCK_WF_WIDTH    = 256
) (
  input  logic clk,
  input  logic rst,
  gpio_config_deserializer_if.slave bus
);
  localparam int NUM_LINES = 12;
  localparam int NUM_REGS  = 9;
  localparam int CW        = $clog2(SYNC_STAGES + 2);
  localparam logic [CW-1:0] ARM_MAX = CW'(SYNC_STAGES + 1);

  logic [NUM_LINES-1:0] lvl, prev;

  generate
    for (genvar g = 0; g < NUM_LINES; g++) begin : g_line
      gpio_cfg_sync_line #(.SYNC_STAGES(SYNC_STAGES)) u_line (
        .clk  (clk),
        .rst  (rst),
        .d    (bus.gpio_in[g]),
        .lvl  (lvl[g]),
        .prev (prev[g])
      );
    end
    if (GPIO_WIDTH > NUM_LINES) begin : g_hi
      logic unused_gpio_hi;
      assign unused_gpio_hi = ^bus.gpio_in[GPIO_WIDTH-1:NUM_LINES];
    end
  endgenerate

  logic [CW-1:0]               arm_cnt_q, arm_cnt_d;
  logic                        armed;
  logic [NUM_LINES-1:0]        rise_q, rise_d;
  logic                        sdat_q, sdat_d;
  logic                        pl_rst_q, pl_rst_d;
  logic                        trig_q, trig_d;
  logic [NUM_REGS-1:0]         strobe_q, strobe_d;
  logic [MASK_WIDTH-1:0]       mask_q, mask_d;
  logic [SEL_WIDTH-1:0]        sel_q, sel_d;
  logic [CONFIG_REG_WIDTH-1:0] ccnt_q, ccnt_d;
  logic                        mux_q, mux_d;
  logic [ADC_AVG_WIDTH-1:0]    avg_q, avg_d;
  logic [CONFIG_REG_WIDTH-1:0] acyc_q, acyc_d;
  logic [CONFIG_REG_WIDTH-1:0] pre_q, pre_d;
  logic [CONFIG_REG_WIDTH-1:0] post_q, post_d;
  logic [LOCK_WF_WIDTH-1:0]    lock_q, lock_d;

  assign armed = (arm_cnt_q == ARM_MAX);

  always_comb begin
    arm_cnt_d = armed ? arm_cnt_q : arm_cnt_q + CW'(1);
    // Edges are qualified until the synchronisers have flushed post-reset
    // so a line held high across reset never looks like a fresh edge.
    rise_d    = armed ? (lvl & ~prev) : '0;
    // sdata is captured from the same stage as the edge, keeping it aligned.
    sdat_d    = lvl[0];
    pl_rst_d  = lvl[5];

    strobe_d = '0;
    trig_d   = 1'b0;
    mask_d   = mask_q;
    sel_d    = sel_q;
    ccnt_d   = ccnt_q;
    mux_d    = mux_q;
    avg_d    = avg_q;
    acyc_d   = acyc_q;
    pre_d    = pre_q;
    post_d   = post_q;
    lock_d   = lock_q;

    if (pl_rst_q) begin
      // Soft reset holds registers cleared; edge tracking continues upstream.
      mask_d = '0;
      sel_d  = '0;
      ccnt_d = '0;
      mux_d  = 1'b0;
      avg_d  = '0;
      acyc_d = '0;
      pre_d  = '0;
      post_d = '0;
      lock_d = '0;
    end else begin
      strobe_d = {rise_q[11:7], rise_q[4:1]};
      trig_d   = rise_q[6];
      if (rise_q[1])  mask_d = {mask_q[MASK_WIDTH-2:0], sdat_q};
      if (rise_q[2])  sel_d  = {sel_q[SEL_WIDTH-2:0], sdat_q};
      if (rise_q[3])  ccnt_d = {ccnt_q[CONFIG_REG_WIDTH-2:0], sdat_q};
      if (rise_q[4])  mux_d  = sdat_q;
      if (rise_q[7])  avg_d  = {avg_q[ADC_AVG_WIDTH-2:0], sdat_q};
      if (rise_q[8])  acyc_d = {acyc_q[CONFIG_REG_WIDTH-2:0], sdat_q};
      if (rise_q[9])  pre_d  = {pre_q[CONFIG_REG_WIDTH-2:0], sdat_q};
      if (rise_q[10]) post_d = {post_q[CONFIG_REG_WIDTH-2:0], sdat_q};
      if (rise_q[11]) lock_d = {lock_q[LOCK_WF_WIDTH-2:0], sdat_q};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arm_cnt_q <= '0;
      rise_q    <= '0;
      sdat_q    <= 1'b0;
      pl_rst_q  <= 1'b0;
      trig_q    <= 1'b0;
      strobe_q  <= '0;
      mask_q    <= '0;
      sel_q     <= '0;
      ccnt_q    <= '0;
      mux_q     <= 1'b0;
      avg_q     <= '0;
      acyc_q    <= '0;
      pre_q     <= '0;
      post_q    <= '0;
      lock_q    <= '0;
    end else begin
      arm_cnt_q <= arm_cnt_d;
      rise_q    <= rise_d;
      sdat_q    <= sdat_d;
      pl_rst_q  <= pl_rst_d;
      trig_q    <= trig_d;
      strobe_q  <= strobe_d;
      mask_q    <= mask_d;
      sel_q     <= sel_d;
      ccnt_q    <= ccnt_d;
      mux_q     <= mux_d;
      avg_q     <= avg_d;
      acyc_q    <= acyc_d;
      pre_q     <= pre_d;
      post_q    <= post_d;
      lock_q    <= lock_d;
    end
  end

  // Line 0 is data and line 5 is a level, so their edges are never consumed.
  logic unused_rise;
  assign unused_rise = rise_q[0] ^ rise_q[5];

  assign bus.mask_reg          = mask_q;
  assign bus.sel_reg           = sel_q;
  assign bus.cycle_count_reg   = ccnt_q;
  assign bus.mux_set_reg       = mux_q;
  assign bus.adc_num_avg_reg   = avg_q;
  assign bus.adc_num_cycle_reg = acyc_q;
  assign bus.pre_delay_reg     = pre_q;
  assign bus.post_delay_reg    = post_q;
  assign bus.locking_wf_reg    = lock_q;
  assign bus.trigger_pulse     = trig_q;
  assign bus.pl_rst_sync       = pl_rst_q;
  assign bus.shift_strobe      = strobe_q;
  assign bus.sel_onehot_err    = (sel_q != '0) && ((sel_q & (sel_q - SEL_WIDTH'(1))) != '0);
endmodule

// File: tb/tb_gpio_config_deserializer.sv
// Directed self-checking bench for gpio_config_deserializer (SYNC_STAGES = 2).
module tb_gpio_config_deserializer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   strobe_cycles;
  logic [8:0] strobe_or;

  always #5 clk = ~clk;

  gpio_config_deserializer_if #(
    .GPIO_WIDTH(16), .CONFIG_REG_WIDTH(256), .MASK_WIDTH(32),
    .SEL_WIDTH(16), .ADC_AVG_WIDTH(32), .LOCK_WF_WIDTH(256)
  ) bus ();

  gpio_config_deserializer #(
    .GPIO_WIDTH(16), .SYNC_STAGES(2), .CONFIG_REG_WIDTH(256), .MASK_WIDTH(32),
    .SEL_WIDTH(16), .ADC_AVG_WIDTH(32), .LOCK_WF_WIDTH(256)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Serial clock lines: 1,2,3,4,7,8,9,10,11
  localparam logic [15:0] CLK_LINES = 16'h0F9E;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n cycles, sampling 1 time unit after each rising edge.
  task automatic wait_cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (bus.shift_strobe != '0) begin
        strobe_cycles++;
        strobe_or |= bus.shift_strobe;
      end
    end
  endtask

  task automatic clr_strobe_stats();
    strobe_cycles = 0;
    strobe_or     = '0;
  endtask

  task automatic shift_bit(input logic [15:0] lines, input logic b);
    bus.gpio_in    = bus.gpio_in & ~CLK_LINES;
    bus.gpio_in[0] = b;
    wait_cyc(4);
    bus.gpio_in    = bus.gpio_in | lines;
    wait_cyc(4);
    bus.gpio_in    = bus.gpio_in & ~CLK_LINES;
  endtask

  task automatic shift_word(input logic [15:0] lines, input logic [31:0] val, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) shift_bit(lines, val[i]);
  endtask

  initial begin
    int pulses;
    int first;
    clr_strobe_stats();
    // Line 3 and sdata held high across reset.
    bus.gpio_in = 16'h0009;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mask",   bus.mask_reg, 0);
    chk("rst_lock",   bus.locking_wf_reg, 0);
    chk("rst_strobe", bus.shift_strobe, 0);
    chk("rst_trig",   bus.trigger_pulse, 0);
    chk("rst_plrst",  bus.pl_rst_sync, 0);
    chk("rst_selerr", bus.sel_onehot_err, 0);

    // Arming: held-high line must not shift after release.
    rst = 1'b0;
    clr_strobe_stats();
    wait_cyc(10);
    chk("arm_no_strobe", strobe_cycles, 0);
    chk("arm_ccnt_zero", bus.cycle_count_reg, 0);

    // Fresh edge on line 3: strobe exactly after the third edge.
    bus.gpio_in[3] = 1'b0;
    wait_cyc(4);
    bus.gpio_in[3] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (k == 2) chk("lat_e2_strobe", bus.shift_strobe, 0);
      if (k == 3) begin
        chk("lat_e3_strobe", bus.shift_strobe, 9'h004);
        chk("lat_e3_ccnt",   bus.cycle_count_reg, 1);
      end
      if (k == 4) chk("lat_e4_strobe", bus.shift_strobe, 0);
    end
    bus.gpio_in[3] = 1'b0;
    wait_cyc(4);

    // Mask: 36 bits, MSBs dropped.
    clr_strobe_stats();
    shift_word(16'h0002, 32'hDEADBEEF, 32);
    shift_word(16'h0002, 32'h0000000A, 4);
    chk("mask_val",     bus.mask_reg, 32'hEADBEEFA);
    chk("mask_strobes", strobe_cycles, 36);
    chk("mask_str_or",  strobe_or, 9'h001);
    chk("ccnt_kept",    bus.cycle_count_reg, 1);

    // Select one-hot error.
    shift_word(16'h0004, 32'h0011, 16);
    chk("sel_val1", bus.sel_reg, 16'h0011);
    chk("sel_err1", bus.sel_onehot_err, 1);
    shift_word(16'h0004, 32'h0010, 16);
    chk("sel_val2", bus.sel_reg, 16'h0010);
    chk("sel_err2", bus.sel_onehot_err, 0);

    // Simultaneous edges on pre/post delay.
    clr_strobe_stats();
    shift_word(16'h0600, 32'h7, 3);
    chk("pre_val",       bus.pre_delay_reg, 7);
    chk("post_val",      bus.post_delay_reg, 7);
    chk("pp_strobe_cyc", strobe_cycles, 3);
    chk("pp_strobe_or",  strobe_or, 9'h0C0);

    // Width-1 register is overwritten; adc_num_cycle 8 bits.
    shift_bit(16'h0010, 1'b1);
    chk("mux_set1", bus.mux_set_reg, 1);
    shift_bit(16'h0010, 1'b0);
    chk("mux_set0", bus.mux_set_reg, 0);
    shift_word(16'h0100, 32'h3C, 8);
    chk("acyc_val", bus.adc_num_cycle_reg, 8'h3C);

    // Trigger held high 20 cycles: one pulse, after the third edge.
    wait_cyc(4);
    bus.gpio_in[6] = 1'b1;
    pulses = 0;
    first  = -1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (bus.trigger_pulse) begin
        pulses++;
        if (first < 0) first = k;
      end
    end
    chk("trig_pulses", pulses, 1);
    chk("trig_lat",    first, 3);
    bus.gpio_in[6] = 1'b0;
    wait_cyc(4);

    // Soft reset clears avg register and blocks trigger.
    shift_word(16'h0080, 32'h5, 3);
    chk("avg_val", bus.adc_num_avg_reg, 5);
    pulses = 0;
    clr_strobe_stats();
    bus.gpio_in[5] = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      if (bus.trigger_pulse) pulses++;
      if (bus.shift_strobe != '0) strobe_cycles++;
      if (k == 1) bus.gpio_in[6] = 1'b1;
      if (k == 4) begin
        chk("plrst_level", bus.pl_rst_sync, 1);
        chk("plrst_avg0",  bus.adc_num_avg_reg, 0);
        chk("plrst_mask0", bus.mask_reg, 0);
      end
      if (k == 5) bus.gpio_in[5] = 1'b0;
    end
    chk("plrst_no_trig",  pulses, 0);
    chk("plrst_no_strb",  strobe_cycles, 0);
    chk("plrst_released", bus.pl_rst_sync, 0);
    chk("plrst_avg_stay", bus.adc_num_avg_reg, 0);
    bus.gpio_in[6] = 1'b0;
    wait_cyc(4);

    // Async reset mid-shift of locking waveform.
    shift_word(16'h0800, 32'h7, 3);
    chk("lock_val", bus.locking_wf_reg, 7);
    bus.gpio_in[0] = 1'b1;
    wait_cyc(4);
    bus.gpio_in[11] = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("arst_lock",   bus.locking_wf_reg, 0);
    chk("arst_pre",    bus.pre_delay_reg, 0);
    @(posedge clk); #1;
    chk("arst_lock2",  bus.locking_wf_reg, 0);
    chk("arst_strobe", bus.shift_strobe, 0);
    rst = 1'b0;
    clr_strobe_stats();
    wait_cyc(10);
    chk("rearm_no_strb", strobe_cycles, 0);
    chk("rearm_lock",    bus.locking_wf_reg, 0);
    bus.gpio_in[11] = 1'b0;
    wait_cyc(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
